// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode stage.
// No logic and no latency; the types only.
// No flow control here; handshake behaviour lives in decode_stage.
package decode_pkg;

    // Control bundle carried alongside each instruction into EX
    typedef struct packed {
        logic [3:0] alu_op;
        logic [3:0] bj_inst;
        logic [1:0] wb_sel;
        logic [1:0] width;
        logic       reg_write;
        logic       mem_rd;
        logic       mem_wr;
        logic       unsigned_sel;
        logic       jalr;
        logic       op_a_pc;
    } ctrl_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_t;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU op encoding is {alt, funct3}; alt distinguishes SUB and SRA
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b1000;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    // Branch/jump kind: 1xxx is a conditional branch with funct3 in the low bits
    localparam logic [3:0] BJ_NONE = 4'b0000;
    localparam logic [3:0] BJ_JAL  = 4'b0001;
    localparam logic [3:0] BJ_JALR = 4'b0010;

    // Write-back source select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Only ADD/SUB and SRL/SRA have an alternate form; other funct3 ignore alt
    function automatic logic [3:0] alu_from_funct(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        if (funct3 == 3'b000 || funct3 == 3'b101) begin
            op = {alt, funct3};
        end else begin
            op = {1'b0, funct3};
        end
        return op;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file with two combinational read ports and one write port.
// Reads are same-cycle; writes land on the next rising edge.
// Never stalls: the write port is always accepted, independent of pipeline holds.
module decode_regfile #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wb_en,
    input  logic [$clog2(NREGS)-1:0] i_wb_reg,
    input  logic [XLEN-1:0]          i_wb_data,
    input  logic [$clog2(NREGS)-1:0] i_rs1,
    input  logic [$clog2(NREGS)-1:0] i_rs2,
    output logic [XLEN-1:0]          o_rs1_data,
    output logic [XLEN-1:0]          o_rs2_data
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_byp1;
    logic            w_byp2;

    // Write port; x0 is hardwired so writes to it are dropped
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wb_en && (i_wb_reg != '0)) begin
            r_regs[i_wb_reg] <= i_wb_data;
        end
    end

    // Forward the in-flight write only when bypass is built in
    assign w_byp1 = (BYPASS_EN != 0) && i_wb_en && (i_wb_reg == i_rs1);
    assign w_byp2 = (BYPASS_EN != 0) && i_wb_en && (i_wb_reg == i_rs2);

    assign o_rs1_data = (i_rs1 == '0) ? '0 : (w_byp1 ? i_wb_data : r_regs[i_rs1]);
    assign o_rs2_data = (i_rs2 == '0) ? '0 : (w_byp2 ? i_wb_data : r_regs[i_rs2]);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode: register read, immediate generation, load-use detection, EX register.
// One cycle from fetch inputs to ex_* outputs.
// Holds on stall_in, inserts a bubble on load-use hazard or flush; flush wins.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_if_valid,
    input  logic [31:0]              i_if_instr,
    input  logic [XLEN-1:0]          i_if_pc,
    input  logic                     i_stall_in,
    input  logic                     i_flush,
    input  logic                     i_wb_en,
    input  logic [$clog2(NREGS)-1:0] i_wb_reg,
    input  logic [XLEN-1:0]          i_wb_data,
    output logic                     o_if_stall,
    output logic                     o_ex_valid,
    output logic [XLEN-1:0]          o_ex_rs1_data,
    output logic [XLEN-1:0]          o_ex_rs2_data,
    output logic [XLEN-1:0]          o_ex_imm,
    output logic [XLEN-1:0]          o_ex_pc,
    output logic [$clog2(NREGS)-1:0] o_ex_rs1,
    output logic [$clog2(NREGS)-1:0] o_ex_rs2,
    output logic [$clog2(NREGS)-1:0] o_ex_rd,
    output ctrl_t                    o_ex_ctrl
);

    localparam int RAW = $clog2(NREGS);

    // Field extraction
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [RAW-1:0]  w_rs1;
    logic [RAW-1:0]  w_rs2;
    logic [RAW-1:0]  w_rd;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    assign w_opcode = i_if_instr[6:0];
    assign w_funct3 = i_if_instr[14:12];
    assign w_rs1    = i_if_instr[15 +: RAW];
    assign w_rs2    = i_if_instr[20 +: RAW];
    assign w_rd     = i_if_instr[7 +: RAW];

    decode_regfile #(
        .XLEN      (XLEN),
        .NREGS     (NREGS),
        .BYPASS_EN (BYPASS_EN)
    ) u_regfile (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wb_en    (i_wb_en),
        .i_wb_reg   (i_wb_reg),
        .i_wb_data  (i_wb_data),
        .i_rs1      (w_rs1),
        .i_rs2      (w_rs2),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data)
    );

    // Candidate immediates, all sign-extended from bit 31
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm32;
    logic [XLEN-1:0] w_imm;

    assign w_imm_i = {{20{i_if_instr[31]}}, i_if_instr[31:20]};
    assign w_imm_s = {{20{i_if_instr[31]}}, i_if_instr[31:25], i_if_instr[11:7]};
    assign w_imm_b = {{19{i_if_instr[31]}}, i_if_instr[31], i_if_instr[7],
                      i_if_instr[30:25], i_if_instr[11:8], 1'b0};
    assign w_imm_u = {i_if_instr[31:12], 12'b0};
    assign w_imm_j = {{11{i_if_instr[31]}}, i_if_instr[31], i_if_instr[19:12],
                      i_if_instr[20], i_if_instr[30:21], 1'b0};

    imm_type_t w_imm_type;
    ctrl_t     w_ctrl;

    // Opcode decode; anything outside the RV32I table leaves ctrl all zero
    always_comb begin
        w_ctrl     = '0;
        w_imm_type = IMM_NONE;
        case (w_opcode)
            OPC_LUI: begin
                w_imm_type       = IMM_U;
                w_ctrl.alu_op    = ALU_PASS_B;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                w_imm_type       = IMM_U;
                w_ctrl.alu_op    = ALU_ADD;
                w_ctrl.op_a_pc   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_JAL: begin
                w_imm_type       = IMM_J;
                w_ctrl.alu_op    = ALU_ADD;
                w_ctrl.bj_inst   = BJ_JAL;
                w_ctrl.wb_sel    = WB_PC4;
                w_ctrl.op_a_pc   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_JALR: begin
                w_imm_type       = IMM_I;
                w_ctrl.alu_op    = ALU_ADD;
                w_ctrl.bj_inst   = BJ_JALR;
                w_ctrl.jalr      = 1'b1;
                w_ctrl.wb_sel    = WB_PC4;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm_type          = IMM_B;
                w_ctrl.alu_op       = ALU_SUB;
                w_ctrl.bj_inst      = {1'b1, w_funct3};
                w_ctrl.unsigned_sel = w_funct3[1];
            end
            OPC_LOAD: begin
                w_imm_type          = IMM_I;
                w_ctrl.alu_op       = ALU_ADD;
                w_ctrl.mem_rd       = 1'b1;
                w_ctrl.reg_write    = 1'b1;
                w_ctrl.wb_sel       = WB_MEM;
                w_ctrl.width        = w_funct3[1:0];
                w_ctrl.unsigned_sel = w_funct3[2];
            end
            OPC_STORE: begin
                w_imm_type    = IMM_S;
                w_ctrl.alu_op = ALU_ADD;
                w_ctrl.mem_wr = 1'b1;
                w_ctrl.width  = w_funct3[1:0];
            end
            OPC_OP_IMM: begin
                // Bit 30 is immediate data except on shifts, where it selects SRAI
                w_imm_type       = IMM_I;
                w_ctrl.alu_op    = alu_from_funct(w_funct3, (w_funct3 == 3'b101) & i_if_instr[30]);
                w_ctrl.reg_write = 1'b1;
            end
            OPC_OP: begin
                w_imm_type       = IMM_NONE;
                w_ctrl.alu_op    = alu_from_funct(w_funct3, i_if_instr[30]);
                w_ctrl.reg_write = 1'b1;
            end
            default: begin
                w_ctrl     = '0;
                w_imm_type = IMM_NONE;
            end
        endcase
    end

    // Immediate select by format
    always_comb begin
        w_imm32 = '0;
        case (w_imm_type)
            IMM_I:   w_imm32 = w_imm_i;
            IMM_S:   w_imm32 = w_imm_s;
            IMM_B:   w_imm32 = w_imm_b;
            IMM_U:   w_imm32 = w_imm_u;
            IMM_J:   w_imm32 = w_imm_j;
            default: w_imm32 = '0;
        endcase
    end

    assign w_imm = XLEN'($signed(w_imm32));

    // EX register state
    logic            r_ex_valid;
    logic [XLEN-1:0] r_ex_rs1_data;
    logic [XLEN-1:0] r_ex_rs2_data;
    logic [XLEN-1:0] r_ex_imm;
    logic [XLEN-1:0] r_ex_pc;
    logic [RAW-1:0]  r_ex_rs1;
    logic [RAW-1:0]  r_ex_rs2;
    logic [RAW-1:0]  r_ex_rd;
    ctrl_t           r_ex_ctrl;

    // A load in EX whose destination feeds this instruction cannot forward in time
    logic w_hazard;
    assign w_hazard = r_ex_valid & r_ex_ctrl.mem_rd & (r_ex_rd != '0) & i_if_valid &
                      ((r_ex_rd == w_rs1) | (r_ex_rd == w_rs2));

    assign o_if_stall = (i_stall_in | w_hazard) & ~i_flush;

    // EX register update: flush > stall_in > hazard > advance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_pc       <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_ctrl     <= '0;
        end else if (i_flush || (!i_stall_in && w_hazard)) begin
            r_ex_valid    <= 1'b0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_pc       <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_ctrl     <= '0;
        end else if (!i_stall_in) begin
            r_ex_valid    <= i_if_valid;
            r_ex_rs1_data <= w_rs1_data;
            r_ex_rs2_data <= w_rs2_data;
            r_ex_imm      <= w_imm;
            r_ex_pc       <= i_if_pc;
            r_ex_rs1      <= w_rs1;
            r_ex_rs2      <= w_rs2;
            r_ex_rd       <= w_rd;
            r_ex_ctrl     <= w_ctrl;
        end
    end

    assign o_ex_valid    = r_ex_valid;
    assign o_ex_rs1_data = r_ex_rs1_data;
    assign o_ex_rs2_data = r_ex_rs2_data;
    assign o_ex_imm      = r_ex_imm;
    assign o_ex_pc       = r_ex_pc;
    assign o_ex_rs1      = r_ex_rs1;
    assign o_ex_rs2      = r_ex_rs2;
    assign o_ex_rd       = r_ex_rd;
    assign o_ex_ctrl     = r_ex_ctrl;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (bypass on / off) fed identical stimulus.
// Expected EX contents come from a reference model and are queued per clock edge.
// A monitor pops one expectation per instance after every rising edge.
module tb_decode_stage;
    import decode_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        ctrl_t       ctrl;
    } ex_t;

    localparam logic [31:0] ADD6 = 32'h0002_8333;  // add x6,x5,x0
    localparam logic [31:0] LW7  = 32'h0000_A383;  // lw  x7,0(x1)
    localparam logic [31:0] ADD8 = 32'h0023_8433;  // add x8,x7,x2
    localparam logic [31:0] ADD9 = 32'h0000_04B3;  // add x9,x0,x0
    localparam logic [31:0] BEQ  = 32'hFE00_0EE3;
    localparam logic [31:0] JAL  = 32'h8000_00EF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, stall_in, flush, wb_en;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [4:0]  wb_reg;

    logic        o1_stall, o1_valid, o0_stall, o0_valid;
    logic [31:0] o1_rs1d, o1_rs2d, o1_imm, o1_pc, o0_rs1d, o0_rs2d, o0_imm, o0_pc;
    logic [4:0]  o1_rs1, o1_rs2, o1_rd, o0_rs1, o0_rs2, o0_rd;
    ctrl_t       o1_ctrl, o0_ctrl;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .NREGS(32), .BYPASS_EN(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_if_valid(if_valid), .i_if_instr(if_instr),
        .i_if_pc(if_pc), .i_stall_in(stall_in), .i_flush(flush), .i_wb_en(wb_en),
        .i_wb_reg(wb_reg), .i_wb_data(wb_data), .o_if_stall(o1_stall),
        .o_ex_valid(o1_valid), .o_ex_rs1_data(o1_rs1d), .o_ex_rs2_data(o1_rs2d),
        .o_ex_imm(o1_imm), .o_ex_pc(o1_pc), .o_ex_rs1(o1_rs1), .o_ex_rs2(o1_rs2),
        .o_ex_rd(o1_rd), .o_ex_ctrl(o1_ctrl)
    );

    decode_stage #(.XLEN(32), .NREGS(32), .BYPASS_EN(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_if_valid(if_valid), .i_if_instr(if_instr),
        .i_if_pc(if_pc), .i_stall_in(stall_in), .i_flush(flush), .i_wb_en(wb_en),
        .i_wb_reg(wb_reg), .i_wb_data(wb_data), .o_if_stall(o0_stall),
        .o_ex_valid(o0_valid), .o_ex_rs1_data(o0_rs1d), .o_ex_rs2_data(o0_rs2d),
        .o_ex_imm(o0_imm), .o_ex_pc(o0_pc), .o_ex_rs1(o0_rs1), .o_ex_rs2(o0_rs2),
        .o_ex_rd(o0_rd), .o_ex_ctrl(o0_ctrl)
    );

    ex_t a1, a0;
    assign a1 = {o1_valid, o1_rs1d, o1_rs2d, o1_imm, o1_pc, o1_rs1, o1_rs2, o1_rd, o1_ctrl};
    assign a0 = {o0_valid, o0_rs1d, o0_rs2d, o0_imm, o0_pc, o0_rs1, o0_rs2, o0_rd, o0_ctrl};

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_rf [32];
    ex_t         m_ex1, m_ex0;
    ex_t         q1[$], q0[$];

    function automatic logic [3:0] m_alu(input logic [2:0] f3, input logic b30, input bit is_reg);
        case (f3)
            3'd0:    return (is_reg && b30) ? 4'h8 : 4'h0;   // SUB only for register form
            3'd5:    return b30 ? 4'hD : 4'h5;               // SRA / SRL
            default: return {1'b0, f3};
        endcase
    endfunction

    function automatic ctrl_t m_ctrl(input logic [31:0] ins);
        ctrl_t c;
        logic [2:0] f3;
        c  = '0;
        f3 = ins[14:12];
        case (ins[6:0])
            7'h37: begin c.alu_op = 4'hF; c.reg_write = 1'b1; end
            7'h17: begin c.op_a_pc = 1'b1; c.reg_write = 1'b1; end
            7'h6F: begin c.bj_inst = 4'h1; c.wb_sel = 2'd2; c.op_a_pc = 1'b1; c.reg_write = 1'b1; end
            7'h67: begin c.bj_inst = 4'h2; c.jalr = 1'b1; c.wb_sel = 2'd2; c.reg_write = 1'b1; end
            7'h63: begin c.alu_op = 4'h8; c.bj_inst = {1'b1, f3}; c.unsigned_sel = f3[1]; end
            7'h03: begin
                c.mem_rd = 1'b1; c.reg_write = 1'b1; c.wb_sel = 2'd1;
                c.width = f3[1:0]; c.unsigned_sel = f3[2];
            end
            7'h23: begin c.mem_wr = 1'b1; c.width = f3[1:0]; end
            7'h13: begin c.reg_write = 1'b1; c.alu_op = m_alu(f3, ins[30], 1'b0); end
            7'h33: begin c.reg_write = 1'b1; c.alu_op = m_alu(f3, ins[30], 1'b1); end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] i);
        case (i[6:0])
            7'h37, 7'h17:        return {i[31:12], 12'b0};
            7'h6F:               return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            7'h67, 7'h03, 7'h13: return {{20{i[31]}}, i[31:20]};
            7'h23:               return {{20{i[31]}}, i[31:25], i[11:7]};
            7'h63:               return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            default:             return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx, input bit byp, input bit we,
                                           input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 5'd0) return 32'h0;
        if (byp && we && wr == idx) return wd;
        return m_rf[idx];
    endfunction

    // One clock of stimulus: drive at the falling edge, check if_stall, queue the next EX state
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input bit st, input bit fl, input bit we,
                         input logic [4:0] wr, input logic [31:0] wd);
        ex_t n1, n0;
        logic [4:0] s1, s2;
        bit hz;
        @(negedge clk);
        rst_n = 1'b1;
        if_valid = v; if_instr = ins; if_pc = pc; stall_in = st; flush = fl;
        wb_en = we; wb_reg = wr; wb_data = wd;
        #1;
        s1 = ins[19:15];
        s2 = ins[24:20];
        hz = m_ex1.valid && m_ex1.ctrl.mem_rd && (m_ex1.rd != 5'd0) && v &&
             (m_ex1.rd == s1 || m_ex1.rd == s2);
        chk("if_stall", 256'({o1_stall, o0_stall}), 256'({2{(st || hz) && !fl}}));
        if (fl || (!st && hz)) begin
            n1 = '0;
            n0 = '0;
        end else if (st) begin
            n1 = m_ex1;
            n0 = m_ex0;
        end else begin
            n1.valid = v;
            n1.rs1   = s1;
            n1.rs2   = s2;
            n1.rd    = ins[11:7];
            n1.imm   = m_imm(ins);
            n1.pc    = pc;
            n1.ctrl  = m_ctrl(ins);
            n1.rs1d  = m_read(s1, 1'b1, we, wr, wd);
            n1.rs2d  = m_read(s2, 1'b1, we, wr, wd);
            n0       = n1;
            n0.rs1d  = m_read(s1, 1'b0, we, wr, wd);
            n0.rs2d  = m_read(s2, 1'b0, we, wr, wd);
        end
        if (we && wr != 5'd0) m_rf[wr] = wd;
        q1.push_back(n1);
        q0.push_back(n0);
        m_ex1 = n1;
        m_ex0 = n0;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // ---------------- monitor ----------------
    ex_t mon_e;
    always @(posedge clk) begin
        #1;
        if (q1.size() > 0) begin
            mon_e = q1.pop_front();
            chk("ex_bypass_on", 256'(a1), 256'(mon_e));
        end
        if (q0.size() > 0) begin
            mon_e = q0.pop_front();
            chk("ex_bypass_off", 256'(a0), 256'(mon_e));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                  7'h03, 7'h23, 7'h13, 7'h33, 7'h0B};
        logic [31:0] ins;
        rst_n = 1'b1;
        if_valid = 1'b0; if_instr = '0; if_pc = '0; stall_in = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_reg = '0; wb_data = '0;
        foreach (m_rf[i]) m_rf[i] = 32'h0;
        m_ex1 = '0;
        m_ex0 = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_ex_on", 256'(a1), 256'(0));
        chk("reset_ex_off", 256'(a0), 256'(0));
        chk("reset_stall", 256'({o1_stall, o0_stall}), 256'(0));

        // Same-cycle write-back vs read of x5
        cycle(1'b1, ADD6, 32'h0000_1000, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234);
        after_edge();
        chk("bypass_on_x5", 256'(o1_rs1d), 256'(32'h1234));
        chk("bypass_off_x5", 256'(o0_rs1d), 256'(32'h0));

        // Load-use: one stall cycle, a bubble, then the dependent add
        cycle(1'b1, LW7, 32'h0000_1004, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(1'b1, ADD8, 32'h0000_1008, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        after_edge();
        chk("loaduse_bubble", 256'(o1_valid), 256'(0));
        cycle(1'b1, ADD8, 32'h0000_1008, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        after_edge();
        chk("loaduse_add_rs1", 256'({o1_valid, o1_rs1}), 256'({1'b1, 5'd7}));

        // Flush overrides both stall_in and a pending hazard
        cycle(1'b1, LW7, 32'h0000_2000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(1'b1, ADD8, 32'h0000_2004, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        after_edge();
        chk("flush_bubble", 256'({o1_valid, o1_ctrl}), 256'(0));

        // Extreme immediates
        cycle(1'b1, BEQ, 32'h0000_3000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        after_edge();
        chk("beq_imm", 256'(o1_imm), 256'(32'hFFFF_FFFC));
        cycle(1'b1, JAL, 32'h0000_3004, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        after_edge();
        chk("jal_imm", 256'(o1_imm), 256'(32'hFFF0_0000));

        // Hold for three cycles while fetch changes and x0 is written
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b1, 5'd0, $urandom | 32'h1);
        end
        cycle(1'b1, ADD9, 32'h0000_4000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        after_edge();
        chk("x0_reads_zero", 256'({o1_valid, o1_rs1d, o1_rs2d}), 256'({1'b1, 64'h0}));

        // Asynchronous reset while a load-use hazard is holding fetch
        cycle(1'b1, LW7, 32'h0000_5000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        if_valid = 1'b1; if_instr = ADD8; if_pc = 32'h0000_5004;
        stall_in = 1'b0; flush = 1'b0; wb_en = 1'b0;
        #1;
        chk("hazard_before_reset", 256'(o1_stall), 256'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_ex_on", 256'(a1), 256'(0));
        chk("async_reset_ex_off", 256'(a0), 256'(0));
        chk("async_reset_stall", 256'({o1_stall, o0_stall}), 256'(0));
        foreach (m_rf[i]) m_rf[i] = 32'h0;
        m_ex1 = '0;
        m_ex0 = '0;
        cycle(1'b1, ADD8, 32'h0000_5004, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        after_edge();
        chk("reset_release_advance", 256'({o1_valid, o1_rs1}), 256'({1'b1, 5'd7}));

        // Randomized traffic with small register indices to provoke hazards and bypass
        for (int k = 0; k < 400; k++) begin
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 10)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            cycle($urandom_range(0, 3) != 0, ins, $urandom,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end
        after_edge();
        chk("queue_drained", 256'(q1.size() + q0.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
